audio_output_serializer: RTL
============================

Name: audio_output_serializer

Overview:
- Consumer end of the processingGrid output stream. Takes o_outputReady/o_output samples: signed fixed point, c_datawidth bits, g_fractionLength fraction bits.
- Buffers the samples in a small FIFO, converts each to saturated 16-bit PCM, and transmits it as I2S (mono, duplicated on left and right) to an external DAC.
- Sits between processingGrid and the board audio pins. It absorbs the mismatch between the grid's bursty timestep rate and the fixed audio frame rate.

Parameters:
- g_fifoDepth, 16, FIFO entries; power of two, minimum 2.
- g_bclkDivider, 4, i_clk cycles per half BCLK period; minimum 1.
- g_fractionLength, c_fractionlength, fraction bits of the input sample.

Ports:
- i_clk  in  1  system clock.
- i_reset  in  1  asynchronous, active-low reset.
- i_sampleValid  in  1  connect to processingGrid o_outputReady; one-cycle strobe per sample.
- i_sample  in  c_datawidth  signed sample; connect to o_output.
- i_clearFlags  in  1  synchronous clear of the sticky flags.
- o_bclk  out  1  I2S bit clock.
- o_lrclk  out  1  I2S word select; 0 = left.
- o_sdata  out  1  I2S serial data.
- o_fifoLevel  out  $clog2(g_fifoDepth)+1  current FIFO occupancy.
- o_overflow  out  1  sticky: a sample was dropped because the FIFO was full.
- o_underflow  out  1  sticky: a frame started with the FIFO empty.

Behaviour:
- Reset (i_reset=0, asynchronous): o_bclk=0, o_lrclk=0, o_sdata=0, o_fifoLevel=0, both flags 0. Divider counter=0, bitCnt=0, shift register=0.
- Conversion happens at FIFO write time (one register stage, off the I2S path):
  - pcm = arithmetic shift of i_sample right by (g_fractionLength-15), i.e. truncation toward minus infinity.
  - Saturate to [-32768, 32767].
  - FIFO stores 16-bit PCM.
  - Sample-to-FIFO latency: 2 cycles from the i_sampleValid edge until o_fifoLevel reflects the sample.
- Clock divider: counter 0..g_bclkDivider-1. o_bclk toggles when the counter wraps. Events are defined on the o_bclk falling edge, i.e. the cycle in which o_bclk goes 1->0.
- Frame: bitCnt 0..31, incremented mod 32 on each BCLK falling edge.
  - o_lrclk = bitCnt[4].
  - o_sdata at bitCnt k = cur[15-((k-1) mod 16)]. At k=0 and k=16 this is the LSB of the previous slot, giving standard I2S one-bit delay. MSB appears at k=1 and k=17.
  - o_lrclk and o_sdata update on the same falling-edge cycle as bitCnt.
- Pop: on the falling edge entering bitCnt=1.
  - FIFO non-empty: cur <= head, pop.
  - FIFO empty: cur <= 0 and o_underflow <= 1.
  - cur is held for the whole frame, so left = right = the same sample. The bit at k=0 of the next frame is the old cur LSB.
- Push: a converted sample is written when the FIFO is not full, or when a pop occurs in the same cycle.
  - Full with no pop: the sample is dropped and o_overflow <= 1.
  - Empty with push and pop in the same cycle: no bypass. The pop sees empty (underflow); the push lands.
- Flags are sticky until i_clearFlags=1. If clear and set happen in the same cycle, set wins.
- o_fifoLevel changes by +1 or -1 per push/pop and is unchanged on a simultaneous push+pop.
- i_reset asserted mid-frame: all state returns to reset values immediately and FIFO contents are discarded. After release, the first BCLK rising edge occurs g_bclkDivider cycles later.

Decomposition:
- pkg_audiovhd additions:
  - c_pcmWidth = 16.
  - c_i2sFrameBits = 32.
  - typedef t_pcmSample (logic signed [c_pcmWidth-1:0]).
  - function f_toPcm(sample, fractionLength): shift plus saturate.
- Sub-module sample_fifo (parameters g_depth and g_width):
  - Synchronous write/read with count, full and empty.
  - Read data is registered head.

Test Plan (g_fractionLength=24, g_bclkDivider=4 -> BCLK period 8 cycles, frame 256 cycles):
- Single strobe i_sample=32'h00400000 -> 16'h2000 in FIFO, level 1. Next frame: o_sdata MSB-first 0010_0000_0000_0000 at bitCnt 1..16 and again at 17..31,0.
- i_sample=32'h01000000 -> 16'h7FFF. i_sample=32'hFF000000 -> 16'h8000. i_sample=32'hFFFFFFFF -> 16'hFFFF (floor, not zero).
- No input for 3 frames -> o_sdata=0 throughout, o_underflow=1 after the first bitCnt=1 edge. i_clearFlags pulse -> 0; rises again at the next frame.
- 17 strobes back-to-back with no pop -> level 16, 17th dropped, o_overflow=1. Drain: the first 16 values are emitted in order, one per frame.
- FIFO full and a strobe in the same cycle as a pop -> level stays 16, no overflow, sample retained.
- i_reset low mid-frame (bitCnt=9) -> o_bclk, o_lrclk, o_sdata and level go 0 asynchronously. After release, a fresh frame starts from bitCnt=0.

Source files
------------

// File: rtl/audio_output_serializer_pkg.sv
// Shared constants, types and the fixed-point to PCM conversion for the audio output path.
// Latency: n/a (package).
// Backpressure: n/a (package).
package audio_output_serializer_pkg;

   localparam int c_datawidth      = 32;
   localparam int c_fractionlength = 24;
   localparam int c_pcmWidth       = 16;
   localparam int c_i2sFrameBits   = 32;

   typedef logic signed [c_pcmWidth-1:0] t_pcmSample;

   // Rescale to 15 fraction bits (floor for right shifts) and saturate to the PCM range.
   function automatic t_pcmSample f_toPcm(input logic signed [c_datawidth-1:0] sample,
                                          input int                            fractionLength);
      logic signed [c_datawidth-1:0] v_scaled;
      if (fractionLength >= c_pcmWidth - 1)
         v_scaled = sample >>> (fractionLength - (c_pcmWidth - 1));
      else
         v_scaled = sample <<< ((c_pcmWidth - 1) - fractionLength);
      // Representable only if every bit above the PCM sign bit is a copy of it.
      if ((&v_scaled[c_datawidth-1:c_pcmWidth-1]) || !(|v_scaled[c_datawidth-1:c_pcmWidth-1]))
         return v_scaled[c_pcmWidth-1:0];
      return v_scaled[c_datawidth-1] ? {1'b1, {(c_pcmWidth-1){1'b0}}}
                                     : {1'b0, {(c_pcmWidth-1){1'b1}}};
   endfunction

endpackage

// File: rtl/audio_output_serializer_sample_fifo.sv
// sample_fifo: small synchronous FIFO with occupancy count; read data is the stored head entry.
// Latency: a write is visible in o_count/o_rdData one cycle later; reads are first-word-fall-through.
// Backpressure: writes while full are ignored unless a read happens in the same cycle; reads while empty are ignored.
// Ports: i_clk, i_reset (async active-low), i_wrEn/i_wrData, i_rdEn, o_rdData, o_count, o_full, o_empty.
module sample_fifo #(
   parameter int g_depth = 16,
   parameter int g_width = 16
) (
   input  logic                       i_clk,
   input  logic                       i_reset,
   input  logic                       i_wrEn,
   input  logic [g_width-1:0]         i_wrData,
   input  logic                       i_rdEn,
   output logic [g_width-1:0]         o_rdData,
   output logic [$clog2(g_depth):0]   o_count,
   output logic                       o_full,
   output logic                       o_empty
);

   localparam int c_ptrW = $clog2(g_depth);

   logic [g_width-1:0] r_mem [g_depth];
   logic [c_ptrW-1:0]  r_wrPtr;
   logic [c_ptrW-1:0]  r_rdPtr;
   logic [c_ptrW:0]    r_count;
   logic               w_wr;
   logic               w_rd;

   assign o_full   = (r_count == (c_ptrW+1)'(g_depth));
   assign o_empty  = (r_count == '0);
   assign o_count  = r_count;
   assign o_rdData = r_mem[r_rdPtr];
   // A read frees the slot this cycle, so a write into a full FIFO is allowed alongside it.
   assign w_rd     = i_rdEn && !o_empty;
   assign w_wr     = i_wrEn && (!o_full || w_rd);

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_wrPtr <= '0;
         r_rdPtr <= '0;
         r_count <= '0;
      end else begin
         if (w_wr) r_wrPtr <= r_wrPtr + c_ptrW'(1);
         if (w_rd) r_rdPtr <= r_rdPtr + c_ptrW'(1);
         if (w_wr && !w_rd)
            r_count <= r_count + (c_ptrW+1)'(1);
         else if (w_rd && !w_wr)
            r_count <= r_count - (c_ptrW+1)'(1);
      end
   end

   always_ff @(posedge i_clk) begin
      if (w_wr) r_mem[r_wrPtr] <= i_wrData;
   end

endmodule

// File: rtl/audio_output_serializer.sv
// audio_output_serializer: buffers grid output samples, converts to 16-bit PCM, sends mono I2S (L = R).
// Latency: sample strobe to FIFO level 2 cycles; FIFO head to o_sdata at the next frame's bit 1.
// Backpressure: none upstream; samples arriving while the FIFO is full are dropped and flagged (o_overflow).
// Ports: i_clk, i_reset (async active-low), i_sampleValid/i_sample (grid output), i_clearFlags,
//        o_bclk/o_lrclk/o_sdata (I2S), o_fifoLevel, o_overflow, o_underflow (sticky).
module audio_output_serializer
   import audio_output_serializer_pkg::*;
#(
   parameter int g_fifoDepth      = 16,
   parameter int g_bclkDivider    = 4,
   parameter int g_fractionLength = c_fractionlength
) (
   input  logic                            i_clk,
   input  logic                            i_reset,
   input  logic                            i_sampleValid,
   input  logic signed [c_datawidth-1:0]   i_sample,
   input  logic                            i_clearFlags,
   output logic                            o_bclk,
   output logic                            o_lrclk,
   output logic                            o_sdata,
   output logic [$clog2(g_fifoDepth):0]    o_fifoLevel,
   output logic                            o_overflow,
   output logic                            o_underflow
);

   localparam int c_divW    = (g_bclkDivider > 1) ? $clog2(g_bclkDivider) : 1;
   localparam int c_bitCntW = $clog2(c_i2sFrameBits);
   localparam int c_idxW    = $clog2(c_pcmWidth);
   localparam logic [c_divW-1:0] c_divLast = c_divW'(g_bclkDivider - 1);

   logic                 r_pcmVld;
   t_pcmSample           r_pcm;
   logic [c_divW-1:0]    r_divCnt;
   logic                 r_bclk;
   logic                 r_lrclk;
   logic                 r_sdata;
   logic [c_bitCntW-1:0] r_bitCnt;
   t_pcmSample           r_cur;
   logic                 r_overflow;
   logic                 r_underflow;

   logic                 w_divWrap;
   logic                 w_bclkFall;
   logic [c_bitCntW-1:0] w_bitCntNext;
   logic [c_idxW-1:0]    w_bitIdx;
   logic                 w_popSlot;
   logic                 w_pop;
   logic                 w_push;
   logic                 w_full;
   logic                 w_empty;
   t_pcmSample           w_head;
   t_pcmSample           w_curNext;

   assign w_divWrap    = (r_divCnt == c_divLast);
   assign w_bclkFall   = w_divWrap && r_bclk;
   assign w_bitCntNext = r_bitCnt + c_bitCntW'(1);
   // Bit driven for the new count k is cur[15-((k-1) mod 16)]; k-1 is the current count.
   assign w_bitIdx     = ~r_bitCnt[c_idxW-1:0];
   assign w_popSlot    = w_bclkFall && (w_bitCntNext == c_bitCntW'(1));
   assign w_pop        = w_popSlot && !w_empty;
   assign w_push       = r_pcmVld && (!w_full || w_pop);
   // The MSB goes out on the same edge that loads cur, so drive from the next value.
   assign w_curNext    = w_popSlot ? (w_empty ? t_pcmSample'(0) : w_head) : r_cur;

   sample_fifo #(
      .g_depth (g_fifoDepth),
      .g_width (c_pcmWidth)
   ) u_sampleFifo (
      .i_clk    (i_clk),
      .i_reset  (i_reset),
      .i_wrEn   (w_push),
      .i_wrData (r_pcm),
      .i_rdEn   (w_pop),
      .o_rdData (w_head),
      .o_count  (o_fifoLevel),
      .o_full   (w_full),
      .o_empty  (w_empty)
   );

   always_ff @(posedge i_clk or negedge i_reset) begin
      if (!i_reset) begin
         r_pcmVld    <= 1'b0;
         r_pcm       <= '0;
         r_divCnt    <= '0;
         r_bclk      <= 1'b0;
         r_lrclk     <= 1'b0;
         r_sdata     <= 1'b0;
         r_bitCnt    <= '0;
         r_cur       <= '0;
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         // Conversion stage keeps the shift/saturate logic off the serial path.
         r_pcmVld <= i_sampleValid;
         if (i_sampleValid) r_pcm <= f_toPcm(i_sample, g_fractionLength);

         if (w_divWrap) begin
            r_divCnt <= '0;
            r_bclk   <= ~r_bclk;
         end else begin
            r_divCnt <= r_divCnt + c_divW'(1);
         end

         if (w_bclkFall) begin
            r_bitCnt <= w_bitCntNext;
            r_lrclk  <= w_bitCntNext[c_bitCntW-1];
            r_sdata  <= w_curNext[w_bitIdx];
            r_cur    <= w_curNext;
         end

         // Setting a flag takes priority over clearing it in the same cycle.
         if (r_pcmVld && w_full && !w_pop) r_overflow <= 1'b1;
         else if (i_clearFlags)            r_overflow <= 1'b0;

         if (w_popSlot && w_empty)         r_underflow <= 1'b1;
         else if (i_clearFlags)            r_underflow <= 1'b0;
      end
   end

   assign o_bclk      = r_bclk;
   assign o_lrclk     = r_lrclk;
   assign o_sdata     = r_sdata;
   assign o_overflow  = r_overflow;
   assign o_underflow = r_underflow;

endmodule
